// File: rtl/load_store_ctrl.sv
// Load/store sequencer for the execute/memory stage: drives a word-wide memory port,
// splits word-crossing accesses into two transactions and returns one extended response.
module load_store_ctrl #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]      r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_split;
  logic            r_err;
  logic [XLEN-1:0] r_rdata0;
  logic [XLEN-1:0] r_rdata1;

  logic [2:0]        w_req_size;
  logic              w_req_cross;
  logic              w_req_illegal;
  logic              w_req_err;
  logic [3:0]        w_bmask;
  logic [7:0]        w_strb8;
  logic [2*XLEN-1:0] w_wdata64;
  logic [XLEN-1:0]   w_rd_lo;
  logic [XLEN-1:0]   w_base;
  logic              w_mem_phase;
  logic              w_second;

  function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] d,
                                                 input logic [2:0] f3);
    case (f3)
      3'b000:  f_load_ext = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b001:  f_load_ext = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b100:  f_load_ext = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b101:  f_load_ext = {{(XLEN-16){1'b0}}, d[15:0]};
      default: f_load_ext = d;
    endcase
  endfunction

  // Request decode: an access crosses a word when offset + size exceeds 4 bytes.
  always_comb begin
    w_req_size = 3'd4;
    case (req_funct3[1:0])
      2'b00:   w_req_size = 3'd1;
      2'b01:   w_req_size = 3'd2;
      default: w_req_size = 3'd4;
    endcase
  end

  assign w_req_cross   = (({1'b0, req_addr[1:0]}) + w_req_size) > 3'd4;
  assign w_req_illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));
  assign w_req_err     = w_req_illegal | (w_req_cross & ~MISALIGN_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= req_funct3;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_split  <= w_req_cross;
          r_err    <= w_req_err;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
          r_state  <= w_req_err ? S_RESP : S_REQ0;
        end
        S_REQ0: if (mem_ready) begin
          if (r_we) r_state <= r_split ? S_REQ1 : S_RESP;
          else      r_state <= S_WAIT0;
        end
        S_WAIT0: if (mem_rvalid) begin
          r_rdata0 <= mem_rdata;
          r_state  <= r_split ? S_REQ1 : S_RESP;
        end
        S_REQ1: if (mem_ready) r_state <= r_we ? S_RESP : S_WAIT1;
        S_WAIT1: if (mem_rvalid) begin
          r_rdata1 <= mem_rdata;
          r_state  <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane shifting: access 0 takes the low half of the 64-bit window, access 1 the high half.
  always_comb begin
    w_bmask = 4'b1111;
    case (r_funct3[1:0])
      2'b00:   w_bmask = 4'b0001;
      2'b01:   w_bmask = 4'b0011;
      default: w_bmask = 4'b1111;
    endcase
  end

  assign w_strb8     = {4'b0000, w_bmask} << r_addr[1:0];
  assign w_wdata64   = {{XLEN{1'b0}}, r_wdata} << {r_addr[1:0], 3'b000};
  assign w_rd_lo     = XLEN'({r_rdata1, r_rdata0} >> {r_addr[1:0], 3'b000});
  assign w_base      = {r_addr[XLEN-1:2], 2'b00};
  assign w_mem_phase = (r_state == S_REQ0) | (r_state == S_REQ1);
  assign w_second    = (r_state == S_REQ1);

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign mem_valid = w_mem_phase;
  assign mem_we    = w_mem_phase & r_we;
  assign mem_addr  = !w_mem_phase ? '0 : (w_second ? w_base + XLEN'(4) : w_base);
  assign mem_wstrb = !(w_mem_phase & r_we) ? 4'b0000 : (w_second ? w_strb8[7:4] : w_strb8[3:0]);
  assign mem_wdata = !(w_mem_phase & r_we) ? '0
                   : (w_second ? w_wdata64[2*XLEN-1:XLEN] : w_wdata64[XLEN-1:0]);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = (r_state == S_RESP) & r_err;
  assign rsp_rdata = ((r_state == S_RESP) & ~r_we & ~r_err) ? f_load_ext(w_rd_lo, r_funct3) : '0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: one splitting instance and one with misalignment disabled.
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic        b_mem_valid, b_mem_ready, b_mem_we, b_mem_rvalid;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;
  logic        b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_ctrl #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  load_store_ctrl #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_noms (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
    .mem_we(b_mem_we), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h80FF1234;
      32'h0000_2000: return 32'h44332211;
      32'h0000_2004: return 32'h88776655;
      32'hFFFF_FFFC: return 32'h11223344;
      32'h0000_0000: return 32'h55667788;
      default:       return 32'hDEADBEEF;
    endcase
  endfunction

  // Issues one load, plays memory (rvalid one cycle after each handshake), checks addresses,
  // response data and the cycle count from accept to rsp_valid.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] a0, input logic [31:0] a1, input int nacc,
                          input logic [31:0] exp_data, input int exp_lat);
    int acc = 0;
    int lat = 0;
    bit got = 0;
    bit pend = 0;
    logic [31:0] pd = '0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!got && lat < 30) begin
      mem_rvalid = 1'b0;
      if (pend) begin mem_rvalid = 1'b1; mem_rdata = pd; pend = 0; end
      if (rsp_valid) begin
        got = 1;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rdata"}, rsp_rdata, exp_data);
        chk({tag, ".err"}, 32'(rsp_err), 32'd0);
      end else if (mem_valid) begin
        chk({tag, ".addr"}, mem_addr, (acc == 0) ? a0 : a1);
        chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, ".we"}, 32'(mem_we), 32'd0);
        acc++;
        pend = 1;
        pd = memword(mem_addr);
      end
      if (!got) begin @(negedge clk); lat++; end
    end
    chk({tag, ".done"}, 32'(got), 32'd1);
    chk({tag, ".nacc"}, acc, nacc);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int nacc,
                           input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                           input int exp_lat);
    int acc = 0;
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!got && lat < 30) begin
      if (rsp_valid) begin
        got = 1;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rdata"}, rsp_rdata, 32'd0);
        chk({tag, ".err"}, 32'(rsp_err), 32'd0);
      end else if (mem_valid) begin
        chk({tag, ".addr"}, mem_addr, (acc == 0) ? a0 : a1);
        chk({tag, ".wstrb"}, 32'(mem_wstrb), 32'((acc == 0) ? s0 : s1));
        chk({tag, ".wdata"}, mem_wdata, (acc == 0) ? d0 : d1);
        chk({tag, ".we"}, 32'(mem_we), 32'd1);
        acc++;
      end
      if (!got) begin @(negedge clk); lat++; end
    end
    chk({tag, ".done"}, 32'(got), 32'd1);
    chk({tag, ".nacc"}, acc, nacc);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".rsp"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".err"}, 32'(rsp_err), 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".mvalid"}, 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0;
    b_mem_ready = 1'b1; b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mvalid", 32'(mem_valid), 32'd0);
    chk("rst.rsp", 32'(rsp_valid), 32'd0);
    chk("rst.maddr", mem_addr, 32'd0);
    chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
    rst_n = 1'b1;

    run_load("lb",  3'b000, 32'h0000_1003, 32'h1000, 32'h0, 1, 32'hFFFF_FF80, 3);
    run_load("lbu", 3'b100, 32'h0000_1003, 32'h1000, 32'h0, 1, 32'h0000_0080, 3);
    run_load("lh",  3'b001, 32'h0000_1002, 32'h1000, 32'h0, 1, 32'hFFFF_80FF, 3);
    run_load("lhu", 3'b101, 32'h0000_1002, 32'h1000, 32'h0, 1, 32'h0000_80FF, 3);
    run_load("lw2", 3'b010, 32'h0000_2002, 32'h2000, 32'h2004, 2, 32'h6655_4433, 5);
    run_load("lh3", 3'b001, 32'h0000_2003, 32'h2000, 32'h2004, 2, 32'h0000_5544, 5);
    run_load("lwa", 3'b010, 32'h0000_2000, 32'h2000, 32'h0, 1, 32'h4433_2211, 3);

    run_store("sw1", 3'b010, 32'h0000_3001, 32'hAABB_CCDD, 2,
              32'h3000, 4'b1110, 32'hBBCC_DD00, 32'h3004, 4'b0001, 32'h0000_00AA, 3);
    run_store("sb1", 3'b000, 32'h0000_6001, 32'h1234_565A, 1,
              32'h6000, 4'b0010, 32'h3456_5A00, 32'h0, 4'b0000, 32'h0, 2);

    // Store held under mem_ready backpressure for three cycles.
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4002; req_wdata = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("sh.mvalid", 32'(mem_valid), 32'd1);
      chk("sh.addr", mem_addr, 32'h4000);
      chk("sh.wstrb", 32'(mem_wstrb), 32'b1100);
      chk("sh.wdata", mem_wdata, 32'h1234_0000);
      chk("sh.rsp", 32'(rsp_valid), 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sh.rsp1", 32'(rsp_valid), 32'd1);
    chk("sh.mvalid0", 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk("sh.pulse", 32'(rsp_valid), 32'd0);

    run_err("ld011", 1'b0, 3'b011, 32'h0000_1000);
    run_err("sb100", 1'b1, 3'b100, 32'h0000_1000);

    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h5001;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("nomis.rsp", 32'(b_rsp_valid), 32'd1);
    chk("nomis.err", 32'(b_rsp_err), 32'd1);
    chk("nomis.rdata", b_rsp_rdata, 32'd0);
    chk("nomis.mvalid", 32'(b_mem_valid), 32'd0);
    @(negedge clk);
    chk("nomis.pulse", 32'(b_rsp_valid), 32'd0);

    // Reset in WAIT0 of a split load, then a stale read return in IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2002;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst6.req0", 32'(mem_valid), 32'd1);
    @(negedge clk);
    chk("rst6.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst6.ready", 32'(req_ready), 32'd1);
    chk("rst6.idle", 32'(busy), 32'd0);
    chk("rst6.mvalid", 32'(mem_valid), 32'd0);
    chk("rst6.rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stale.rsp", 32'(rsp_valid), 32'd0);
    chk("stale.busy", 32'(busy), 32'd0);
    chk("stale.mvalid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk("stale.rsp2", 32'(rsp_valid), 32'd0);

    run_load("lwwrap", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 2, 32'h7788_1122, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
